// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, feeder state encoding and pixel entry type
package vga_pkg;
    localparam int HFP    = 16;
    localparam int HPULSE = 96;
    localparam int HBP    = 48;
    localparam int VFP    = 10;
    localparam int VPULSE = 2;
    localparam int VBP    = 33;
    localparam int PIX_W  = 10;
    typedef enum logic [1:0] {HUNT, ARMED, RUN} feeder_state_t;
    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } pixel_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous show-ahead FIFO with asynchronous active-low clear
// Ports: i_clk, i_rst_n (async clear), i_wr_en/i_din (push), i_rd_en (pop),
//        o_dout (head, combinational), o_full, o_empty, o_level (occupancy)
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 31
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic                     i_rd_en,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;
    assign w_push  = i_wr_en && !o_full;
    assign w_pop   = i_rd_en && !o_empty;
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign o_level = r_wptr - r_rptr;
    assign o_full  = o_level == (AW+1)'(DEPTH);
    assign o_empty = o_level == '0;
    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end
    // Storage needs no reset: clearing the pointers empties the FIFO
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder: buffers a SOF-tagged pixel stream and emits one pixel per active display cycle
// Ports: i_clk, i_rst_n (async active-low); stream in: i_in_valid/o_in_ready/i_in_sof/i_in_r/g/b;
//        timing in: i_frame_start, i_disp_en; out: o_out_r/g/b (registered), o_locked,
//        o_underflow (sticky), o_level (FIFO occupancy)
module vga_pixel_feeder
    import vga_pkg::*;
#(
    parameter int HDISP = 640,
    parameter int VDISP = 480,
    parameter int DEPTH = 64,
    parameter int W     = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_in_sof,
    input  logic [W-1:0]           i_in_r,
    input  logic [W-1:0]           i_in_g,
    input  logic [W-1:0]           i_in_b,
    input  logic                   i_frame_start,
    input  logic                   i_disp_en,
    output logic [W-1:0]           o_out_r,
    output logic [W-1:0]           o_out_g,
    output logic [W-1:0]           o_out_b,
    output logic                   o_locked,
    output logic                   o_underflow,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int NPIX = HDISP * VDISP;
    localparam int CW   = $clog2(NPIX);
    typedef struct packed {
        logic         sof;
        logic [W-1:0] r;
        logic [W-1:0] g;
        logic [W-1:0] b;
    } entry_t;
    feeder_state_t r_state;
    feeder_state_t w_next;
    entry_t        w_head;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_out_r;
    logic [W-1:0]  r_out_g;
    logic [W-1:0]  r_out_b;
    logic          r_ready;
    logic          r_uf;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_pop;
    logic          w_emit;
    logic          w_start;
    logic          w_uf_set;
    // r_ready holds IN_READY low through reset and the release cycle
    assign o_in_ready  = r_ready && !w_full;
    assign w_wr        = i_in_valid && o_in_ready;
    assign o_out_r     = r_out_r;
    assign o_out_g     = r_out_g;
    assign o_out_b     = r_out_b;
    assign o_locked    = r_state == RUN;
    assign o_underflow = r_uf;
    pixel_fifo #(.DEPTH(DEPTH), .WIDTH(3*W+1)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wr_en (w_wr),
        .i_rd_en (w_pop),
        .i_din   ({i_in_sof, i_in_r, i_in_g, i_in_b}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= HUNT;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_emit   = 1'b0;
        w_start  = 1'b0;
        w_uf_set = 1'b0;
        case (r_state)
            HUNT: begin
                if (!w_empty) begin
                    if (w_head.sof) w_next = ARMED;
                    else            w_pop  = 1'b1;
                end
            end
            ARMED: begin
                if (i_frame_start) begin
                    w_next  = RUN;
                    w_start = 1'b1;
                end
            end
            RUN: begin
                if (i_disp_en) begin
                    if (w_empty) begin
                        w_uf_set = 1'b1;
                        w_next   = HUNT;
                    // SOF must coincide exactly with frame position 0: early SOF
                    // waits for the next frame, a missing SOF re-hunts
                    end else if (w_head.sof != (r_cnt == '0)) begin
                        w_next = w_head.sof ? ARMED : HUNT;
                    end else begin
                        w_pop  = 1'b1;
                        w_emit = 1'b1;
                    end
                end else if (i_frame_start && r_cnt != '0) begin
                    w_next = HUNT;
                end
            end
            default: w_next = HUNT;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_uf    <= 1'b0;
            r_ready <= 1'b0;
            r_out_r <= '0;
            r_out_g <= '0;
            r_out_b <= '0;
        end else begin
            r_ready <= 1'b1;
            r_cnt   <= w_start ? '0 : w_emit ? ((r_cnt == CW'(NPIX-1)) ? '0 : r_cnt + 1'b1) : r_cnt;
            r_uf    <= w_start ? 1'b0 : (w_uf_set || r_uf);
            r_out_r <= w_emit ? w_head.r : '0;
            r_out_g <= w_emit ? w_head.g : '0;
            r_out_b <= w_emit ? w_head.b : '0;
        end
    end
endmodule

// File: tb/tb_vga_pixel_feeder.sv
// tb_vga_pixel_feeder: directed and random checks of vga_pixel_feeder against a queue-based model
module tb_vga_pixel_feeder;
    localparam int HDISP = 4;
    localparam int VDISP = 2;
    localparam int DEPTH = 8;
    localparam int W     = 10;
    localparam int NPIX  = HDISP * VDISP;
    localparam int M_HUNT = 0, M_ARMED = 1, M_RUN = 2;
    typedef struct packed {
        logic         sof;
        logic [W-1:0] r;
        logic [W-1:0] g;
        logic [W-1:0] b;
    } ent_t;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_sof = 0;
    logic [W-1:0] in_r = 0, in_g = 0, in_b = 0;
    logic         frame_start = 0;
    logic         disp_en = 0;
    logic         in_ready, locked, underflow;
    logic [W-1:0] out_r, out_g, out_b;
    logic [3:0]   level;

    int   errors = 0;
    int   checks = 0;
    ent_t q[$];
    int   mode = M_HUNT;
    int   cnt = 0;
    bit   uf = 0;
    bit   rdy_en = 0;
    bit   last_acc = 0;
    ent_t mout = '0;

    always #5 clk = ~clk;

    vga_pixel_feeder #(.HDISP(HDISP), .VDISP(VDISP), .DEPTH(DEPTH), .W(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_sof(in_sof), .i_in_r(in_r), .i_in_g(in_g), .i_in_b(in_b),
        .i_frame_start(frame_start), .i_disp_en(disp_en),
        .o_out_r(out_r), .o_out_g(out_g), .o_out_b(out_b),
        .o_locked(locked), .o_underflow(underflow), .o_level(level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic ent_t px(input int n, input bit s);
        ent_t e;
        e.sof = s;
        e.r = W'(n);
        e.g = W'(n);
        e.b = W'(n);
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        mode = M_HUNT;
        cnt = 0;
        uf = 0;
        rdy_en = 0;
        mout = '0;
    endtask

    task automatic cmp_all(input string tag);
        check({tag, ".r"}, 32'(out_r), 32'(mout.r));
        check({tag, ".g"}, 32'(out_g), 32'(mout.g));
        check({tag, ".b"}, 32'(out_b), 32'(mout.b));
        check({tag, ".locked"}, 32'(locked), (mode == M_RUN) ? 1 : 0);
        check({tag, ".underflow"}, 32'(underflow), 32'(uf));
        check({tag, ".level"}, 32'(level), q.size());
        check({tag, ".ready"}, 32'(in_ready), (rdy_en && q.size() < DEPTH) ? 1 : 0);
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it
    task automatic step(input bit v, input ent_t e, input bit fs, input bit de, input string tag);
        bit   rdy;
        bit   pop;
        ent_t nout;
        in_valid = v;
        {in_sof, in_r, in_g, in_b} = e;
        frame_start = fs;
        disp_en = de;
        @(posedge clk);
        last_acc = 0;
        if (rst_n) begin
            rdy = rdy_en && q.size() < DEPTH;
            last_acc = v && rdy;
            pop = 0;
            nout = '0;
            if (mode == M_HUNT) begin
                if (q.size() > 0) begin
                    if (q[0].sof) mode = M_ARMED;
                    else pop = 1;
                end
            end else if (mode == M_ARMED) begin
                if (fs) begin
                    mode = M_RUN;
                    cnt = 0;
                    uf = 0;
                end
            end else if (de) begin
                if (q.size() == 0) begin
                    uf = 1;
                    mode = M_HUNT;
                end else if (q[0].sof && cnt != 0) begin
                    mode = M_ARMED;
                end else if (!q[0].sof && cnt == 0) begin
                    mode = M_HUNT;
                end else begin
                    pop = 1;
                    nout = q[0];
                    cnt = (cnt + 1) % NPIX;
                end
            end else if (fs && cnt != 0) begin
                mode = M_HUNT;
            end
            if (pop) void'(q.pop_front());
            if (last_acc) q.push_back(e);
            mout = nout;
            rdy_en = 1;
        end
        #1;
        cmp_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, "idle");
    endtask

    task automatic push(input ent_t e);
        for (int t = 0; t < 20; t++) begin
            step(1, e, 0, 0, "push");
            if (last_acc) break;
        end
        check("push_acc", 32'(last_acc), 1);
    endtask

    task automatic pulse_fs();
        step(0, '0, 1, 0, "fs");
    endtask

    initial begin
        // Reset held with valid asserted
        for (int i = 0; i < 3; i++) begin
            step(1, px(5, 1), 0, 0, "rst");
            check("rst_ready", 32'(in_ready), 0);
            check("rst_level", 32'(level), 0);
        end
        rst_n = 1;
        #1;
        check("rel_ready0", 32'(in_ready), 0);
        idle(1);
        check("rel_ready1", 32'(in_ready), 1);

        // Nominal frame
        for (int n = 1; n <= 8; n++) push(px(n, n == 1));
        pulse_fs();
        check("nom_locked", 32'(locked), 1);
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, 0, 1, "nom_de");
            check("nom_out", 32'(out_r), k);
        end
        check("nom_level", 32'(level), 0);
        check("nom_uf", 32'(underflow), 0);
        idle(1);
        check("nom_blank", 32'(out_r), 0);

        // Underflow after 5 pixels, then recovery
        for (int n = 11; n <= 15; n++) push(px(n, n == 11));
        pulse_fs();
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, 0, 1, "uf_de");
            check("uf_out", 32'(out_r), (k <= 5) ? 10 + k : 0);
        end
        check("uf_flag", 32'(underflow), 1);
        check("uf_locked", 32'(locked), 0);
        for (int n = 1; n <= 8; n++) push(px(n, n == 1));
        pulse_fs();
        check("uf_clr", 32'(underflow), 0);
        check("uf_relock", 32'(locked), 1);
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, 0, 1, "rec_de");
            check("rec_out", 32'(out_r), k);
        end

        // Garbage before SOF
        step(0, '0, 0, 1, "gb_kick");
        for (int i = 0; i < 3; i++) push(px(9, 0));
        for (int n = 1; n <= 8; n++) push(px(n, n == 1));
        pulse_fs();
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, 0, 1, "gb_de");
            check("gb_out", 32'(out_r), k);
        end

        // Early SOF on pixel 5
        for (int n = 21; n <= 28; n++) push(px(n, n == 21 || n == 25));
        pulse_fs();
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, 0, 1, "es_de");
            check("es_out", 32'(out_r), (k <= 4) ? 20 + k : 0);
        end
        check("es_locked", 32'(locked), 0);
        for (int n = 29; n <= 32; n++) push(px(n, 0));
        pulse_fs();
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, 0, 1, "es2_de");
            check("es2_out", 32'(out_r), 24 + k);
        end

        // Short frame
        for (int n = 41; n <= 48; n++) push(px(n, n == 41));
        pulse_fs();
        for (int k = 1; k <= 3; k++) step(0, '0, 0, 1, "sf_de");
        pulse_fs();
        check("sf_locked", 32'(locked), 0);
        idle(5);
        check("sf_drained", 32'(level), 0);

        // Backpressure
        for (int n = 51; n <= 58; n++) push(px(n, n == 51));
        check("bp_level", 32'(level), 8);
        check("bp_ready", 32'(in_ready), 0);
        step(1, px(59, 0), 0, 0, "bp_reject");
        check("bp_level9", 32'(level), 8);
        pulse_fs();
        step(1, px(60, 0), 0, 1, "bp_pop");
        check("bp_pop_level", 32'(level), 7);
        check("bp_pop_ready", 32'(in_ready), 1);
        check("bp_pop_out", 32'(out_r), 51);
        for (int k = 0; k < 7; k++) step(0, '0, 0, 1, "bp_drain");

        // Random traffic with an asynchronous reset in the middle
        for (int c = 0; c < 500; c++) begin
            ent_t e;
            bit de, fs;
            e.sof = ($urandom_range(0, 5) == 0);
            e.r = W'($urandom);
            e.g = W'($urandom);
            e.b = W'($urandom);
            de = ($urandom_range(0, 1) == 1);
            fs = !de && ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 3) != 0, e, fs, de, "rnd");
            if (c == 250) begin
                rst_n = 0;
                #1;
                model_reset();
                cmp_all("arst");
                step(1, e, 0, 1, "arst_hold");
                rst_n = 1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
